psum_packer: RTL and testbench
==============================

# psum_packer

Serial-to-parallel packer for the CNN accelerator's partial-sum path. It gathers `NUM_SUM` consecutive `DATA_WIDTH` words from a valid/ready stream into the packed `NUM_SUM*DATA_WIDTH` vector format consumed by the saturating adder tree. It then presents that vector over a valid/ready output handshake. Word k of a group lands in lane k, at bits `[k*DATA_WIDTH +: DATA_WIDTH]`.

## Interface
- `NUM_SUM`, 8, number of lanes per packed vector (≥2)
- `DATA_WIDTH`, 16, bits per lane
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  upstream word valid
- `in_ready`  out  1  packer can accept a word this cycle
- `in_data`  in  DATA_WIDTH  upstream word
- `in_last`  in  1  final word of a short group (present only with `PSUM_PACKER_ZERO_PAD_EN`)
- `out_valid`  out  1  packed vector valid
- `out_ready`  in  1  downstream accepts vector
- `out_data`  out  NUM_SUM*DATA_WIDTH  packed vector, lane 0 in LSBs
- `out_count`  out  $clog2(NUM_SUM+1)  number of populated lanes in `out_data`

## Operation
- Word accept = `in_valid && in_ready`; vector drain = `out_valid && out_ready`.
- States: FILL (collecting) and HOLD (vector presented).
- FILL: `in_ready`=1 and `out_valid`=0. Each accept writes `in_data` to lane `idx` and increments `idx`.
- FILL→HOLD on an accept with `idx==NUM_SUM-1`. `idx` wraps to 0, and `out_count` is set to NUM_SUM.
- HOLD: `out_valid`=1 and `out_data`/`out_count` are stable until drained. `in_ready` = `out_ready`, with no combinational path from `in_valid`.
- HOLD with drain and no accept → FILL. Buffer is cleared to all zeros and `idx`=0.
- HOLD with drain and simultaneous accept → FILL. Buffer is cleared, the new word goes to lane 0, and `idx`=1.
- HOLD with no drain: no accept is possible, because `in_ready`=0.
- Data is passed unmodified. There is no arithmetic, and lanes are never reordered.
- Reset, including mid-group or in HOLD: state=FILL, `idx`=0, buffer=0, `out_valid`=0, `in_ready`=1, `out_data`=0, `out_count`=0. Any partial group is discarded.

## Timing
- `out_valid` rises the cycle after the NUM_SUM-th accept (1-cycle latency).
- With `out_ready` held high, sustained throughput is one vector per NUM_SUM cycles, with no bubble.
- `out_data`, `out_count` and `out_valid` are registered.
- `in_ready` is combinational from state and `out_ready` only.

## Configuration
- `PSUM_PACKER_ZERO_PAD_EN` defined:
  - `in_last` port exists.
  - An accept with `in_last`=1 at `idx`=k moves the block to HOLD.
  - Lanes k+1..NUM_SUM-1 hold zero (guaranteed by the clear on drain and at reset), and `out_count`=k+1.
  - `in_last` at k=NUM_SUM-1 behaves exactly like a normal full group.
- Not defined:
  - `in_last` port is absent.
  - A group always closes after exactly NUM_SUM words.
  - `out_count` reads NUM_SUM whenever `out_valid`=1, and 0 otherwise.

## Structure
- Shared package `cnn_pkg` holds:
  - the `packer_state_t` enum (FILL, HOLD);
  - the lane-index width function/constant derived from NUM_SUM.
- One natural sub-module is `lane_counter`: a mod-NUM_SUM counter with sync clear, increment enable and terminal-count output. It drives `idx`.
- The lane write-decode and buffer stay in the top module.

## Test plan
- Full group: NUM_SUM=8, DW=16, words 0x0001..0x0008 back-to-back, `out_ready`=1. Expect `out_valid` 1 cycle after the 8th accept, `out_data`=0x0008_0007_0006_0005_0004_0003_0002_0001, and `out_count`=8.
- Backpressure: `out_ready`=0 for 5 cycles after the group completes. Expect `in_ready`=0, `out_data` stable, and no words lost. When `out_ready` rises with `in_valid`=1 and data 0xAAAA, the drain and the accept happen in the same cycle, and the next vector has lane0=0xAAAA.
- Streaming: 32 random words with `in_valid` and `out_ready` constantly 1. Expect 4 vectors matching the scoreboard, spaced 8 cycles apart.
- Reset mid-group: 3 words accepted, then `reset` pulses. Expect all outputs at reset values, then a clean full group of 8 words packed from lane 0.
- Zero pad (macro on): 3 words 0x1111, 0x2222, 0x3333 with `in_last` on the third. Expect `out_data` lanes 3..7 = 0, `out_count`=3, and the next group to start at lane 0.
- Random valid/ready toggling for 10k cycles. Expect scoreboard equality and no accept while `in_ready`=0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN partial-sum path.
// Holds the packer FSM state type and the lane-index width helper.
// No logic; imported by the packer and its lane counter.
package cnn_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } packer_state_t;

    // Bits needed to index num_sum lanes (never less than one).
    function automatic int idx_width(input int num_sum);
        return (num_sum < 2) ? 1 : $clog2(num_sum);
    endfunction

endpackage

// File: rtl/psum_packer_if.sv
// Handshake bundle between the word stream, the packer and the adder tree.
// Carries in_last only when PSUM_PACKER_ZERO_PAD_EN is defined.
// slave = packer side, master = environment (producer + consumer) side.
interface psum_packer_if #(
    parameter int NUM_SUM    = 8,
    parameter int DATA_WIDTH = 16
);
    localparam int CW = $clog2(NUM_SUM + 1);

    logic                           in_valid;
    logic                           in_ready;
    logic [DATA_WIDTH-1:0]          in_data;
`ifdef PSUM_PACKER_ZERO_PAD_EN
    logic                           in_last;
`endif
    logic                           out_valid;
    logic                           out_ready;
    logic [NUM_SUM*DATA_WIDTH-1:0]  out_data;
    logic [CW-1:0]                  out_count;

`ifdef PSUM_PACKER_ZERO_PAD_EN
    modport master (output in_valid, in_data, in_last, out_ready,
                    input  in_ready, out_valid, out_data, out_count);
    modport slave  (input  in_valid, in_data, in_last, out_ready,
                    output in_ready, out_valid, out_data, out_count);
`else
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_count);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_count);
`endif

endinterface

// File: rtl/psum_packer_lane_counter.sv
// Mod-N lane index counter with sync clear, increment enable and terminal count.
// Latency: count updates on the edge after inc/clear; tc is combinational from count.
// No backpressure of its own; the packer gates inc with its accept strobe.
module lane_counter
    import cnn_pkg::*;
#(
    parameter int N = 8,
    parameter int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == W'(N - 1));

    // Clear wins over increment; increment wraps at N-1.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= tc ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/psum_packer.sv
// Packs NUM_SUM consecutive words into one lane vector (word k -> lane k); optional
// short groups via in_last when PSUM_PACKER_ZERO_PAD_EN is defined.
// Latency: out_valid one cycle after the closing accept. Backpressure: in HOLD in_ready = out_ready.
module psum_packer
    import cnn_pkg::*;
#(
    parameter int NUM_SUM    = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    psum_packer_if.slave   bus
);

    localparam int IW = idx_width(NUM_SUM);
    localparam int CW = $clog2(NUM_SUM + 1);

    packer_state_t                          state;
    logic [NUM_SUM-1:0][DATA_WIDTH-1:0]     lanes;
    logic [CW-1:0]                          count_q;
    logic                                   valid_q;
    logic [IW-1:0]                          idx;
    logic                                   idx_tc;
    logic                                   accept;
    logic                                   drain;
    logic                                   last;
    logic                                   close;

    // in_ready depends only on state and out_ready, never on in_valid.
    assign bus.in_ready = (state == FILL) || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign drain        = valid_q && bus.out_ready;

`ifdef PSUM_PACKER_ZERO_PAD_EN
    assign last = bus.in_last;
`else
    assign last = 1'b0;
`endif

    // A group closes on the last lane, or early on in_last.
    assign close = accept && (idx_tc || last);

    lane_counter #(
        .N (NUM_SUM),
        .W (IW)
    ) u_lane_counter (
        .clk   (clk),
        .reset (reset),
        .clear (accept && last),
        .inc   (accept),
        .count (idx),
        .tc    (idx_tc)
    );

    // FILL/HOLD sequencing; the lane buffer doubles as the registered out_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FILL;
            valid_q <= 1'b0;
            count_q <= '0;
            lanes   <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        lanes[idx] <= bus.in_data;
                        if (close) begin
                            state   <= HOLD;
                            valid_q <= 1'b1;
                            count_q <= CW'(idx) + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (drain) begin
                        // Cleared lanes give the zero padding for short groups.
                        lanes <= '0;
                        if (accept) begin
                            lanes[0] <= bus.in_data;
                        end
                        if (close) begin
                            count_q <= CW'(1);
                        end else begin
                            state   <= FILL;
                            valid_q <= 1'b0;
                            count_q <= '0;
                        end
                    end
                end
                default: begin
                    state   <= FILL;
                    valid_q <= 1'b0;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = lanes;
    assign bus.out_count = count_q;

endmodule

// File: tb/tb_psum_packer.sv
// Self-checking bench for psum_packer (NUM_SUM=8, DATA_WIDTH=16).
// Directed vectors with literal expectations plus a queue-based transaction model.
// Exercises PSUM_PACKER_ZERO_PAD_EN paths when that macro is defined.
module tb_psum_packer;

    localparam int NS = 8;
    localparam int DW = 16;
    localparam int VW = NS * DW;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   cyc;

    psum_packer_if #(.NUM_SUM(NS), .DATA_WIDTH(DW)) bus ();

    psum_packer #(.NUM_SUM(NS), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction model ----------------
    typedef struct {
        logic [VW-1:0] d;
        int            c;
    } vec_t;

    vec_t        expq[$];
    logic [DW-1:0] wq[$];
    int          drains[$];
    bit          m_pend;
    bit          m_acc;
    bit          m_last;
    vec_t        m_vec;

    // Every cycle: compare DUT against the pending-vector queue, then apply this cycle's transfers.
    always @(negedge clk) begin
        if (reset) begin
            expq.delete();
            wq.delete();
        end else begin
            m_pend = (expq.size() != 0);
            chk("mon_out_valid", bus.out_valid, m_pend);
            chk("mon_in_ready", bus.in_ready, !m_pend || bus.out_ready);
            if (m_pend) begin
                chk("mon_out_data", bus.out_data, expq[0].d);
                chk("mon_out_count", bus.out_count, expq[0].c);
            end else begin
                chk("mon_idle_count", bus.out_count, 0);
            end
            m_acc = bus.in_valid && (!m_pend || bus.out_ready);
            if (m_pend && bus.out_ready) begin
                void'(expq.pop_front());
                drains.push_back(cyc);
            end
`ifdef PSUM_PACKER_ZERO_PAD_EN
            m_last = bus.in_last;
`else
            m_last = 1'b0;
`endif
            if (m_acc) begin
                wq.push_back(bus.in_data);
                if (wq.size() == NS || m_last) begin
                    m_vec.d = '0;
                    for (int i = 0; i < wq.size(); i++) m_vec.d[i*DW +: DW] = wq[i];
                    m_vec.c = wq.size();
                    expq.push_back(m_vec);
                    wq.delete();
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic push_word(input logic [DW-1:0] d, input bit last);
        bit a;
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
`ifdef PSUM_PACKER_ZERO_PAD_EN
        bus.in_last  = last;
`endif
        n = 0;
        forever begin
            @(negedge clk);
            a = bus.in_ready;
            @(posedge clk);
            #1;
            if (a) break;
            n++;
            if (n > 200) begin
                chk("push_timeout", 1, 0);
                break;
            end
        end
        bus.in_valid = 1'b0;
`ifdef PSUM_PACKER_ZERO_PAD_EN
        bus.in_last  = 1'b0;
`endif
        if (last && 0) bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_out_count"}, bus.out_count, 0);
    endtask

    logic [VW-1:0] held;

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
`ifdef PSUM_PACKER_ZERO_PAD_EN
        bus.in_last   = 1'b0;
`endif
        idle(2);
        check_reset_state("reset");
        reset = 1'b0;
        idle(1);

        // Full group, back-to-back, downstream always ready.
        for (int i = 1; i <= NS; i++) push_word(DW'(i), 1'b0);
        chk("full_valid", bus.out_valid, 1);
        chk("full_data", bus.out_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("full_count", bus.out_count, NS);
        idle(2);

        // Backpressure: vector held for 5 cycles, then drain and accept 0xAAAA together.
        bus.out_ready = 1'b0;
        for (int i = 0; i < NS; i++) push_word(DW'(16'h0011 + i), 1'b0);
        held = 128'h0018_0017_0016_0015_0014_0013_0012_0011;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hAAAA;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_data_stable", bus.out_data, held);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("bp_drained", bus.out_valid, 0);
        for (int i = 1; i < NS; i++) push_word(DW'(16'hB000 + i), 1'b0);
        chk("bp_next_data", bus.out_data, 128'hB007_B006_B005_B004_B003_B002_B001_AAAA);
        idle(2);

        // Streaming: 32 words with valid and ready held high -> 4 vectors, 8 cycles apart.
        drains.delete();
        for (int i = 0; i < 4 * NS; i++) push_word(DW'($urandom), 1'b0);
        idle(3);
        chk("stream_vectors", drains.size(), 4);
        for (int i = 1; i < drains.size(); i++) chk("stream_spacing", drains[i] - drains[i-1], NS);

        // Reset mid-group discards the partial group.
        for (int i = 0; i < 3; i++) push_word(DW'(16'h00E0 + i), 1'b0);
        reset = 1'b1;
        idle(1);
        check_reset_state("midreset");
        reset = 1'b0;
        for (int i = 0; i < NS; i++) push_word(DW'(16'h0021 + i), 1'b0);
        chk("midreset_data", bus.out_data, 128'h0028_0027_0026_0025_0024_0023_0022_0021);
        idle(2);

`ifdef PSUM_PACKER_ZERO_PAD_EN
        // Short group closed by in_last; remaining lanes zero, next group starts at lane 0.
        push_word(16'h1111, 1'b0);
        push_word(16'h2222, 1'b0);
        push_word(16'h3333, 1'b1);
        chk("pad_valid", bus.out_valid, 1);
        chk("pad_data", bus.out_data, 128'h0000_0000_0000_0000_0000_3333_2222_1111);
        chk("pad_count", bus.out_count, 3);
        idle(2);
        for (int i = 0; i < NS; i++) push_word(DW'(16'h0041 + i), 1'b0);
        chk("pad_next_data", bus.out_data, 128'h0048_0047_0046_0045_0044_0043_0042_0041);
        idle(2);
`endif

        // Random valid/ready toggling; the model checks every cycle.
        repeat (10000) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = DW'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
`ifdef PSUM_PACKER_ZERO_PAD_EN
            bus.in_last   = ($urandom_range(0, 7) == 0);
`endif
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
`ifdef PSUM_PACKER_ZERO_PAD_EN
        bus.in_last   = 1'b0;
`endif
        idle(3);
        chk("final_drained", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
